// File: rtl/code_arm_setter.sv
// Arming-side secret code entry: debounced five-key entry, confirmation pass, held reference code.
// Optional build macro ENTRY_TIMEOUT_EN adds an inactivity timeout during ENTER/VERIFY.
module code_arm_setter #(
  parameter int unsigned CODE_LEN    = 4,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              keys,
  input  logic                    arm_req,
  input  logic                    clear,
  output logic [3*CODE_LEN-1:0]   code_out,
  output logic                    code_valid,
  output logic                    armed,
  output logic                    mismatch,
  output logic [7:0]              prog_led
);

  localparam int unsigned NK = 5;
  localparam int unsigned CW = 3 * CODE_LEN;
  localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTER  = 2'd1,
    S_VERIFY = 2'd2,
    S_ARMED  = 2'd3
  } state_t;

  logic [NK-1:0] keys_s1, keys_s2;
  logic [NK-1:0] deb, deb_d, press;
  logic [DW-1:0] deb_cnt [NK];
  logic          arm_s1, arm_s2, arm_d;
  logic          clr_s1, clr_s2;

  state_t        state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [2:0]    shadow     [CODE_LEN];
  logic [2:0]    nxt_shadow [CODE_LEN];
  logic [CW-1:0] nxt_code;
  logic          nxt_valid, nxt_armed, nxt_mismatch;
  logic [7:0]    nxt_led;

  logic          press_any, press_multi, arm_rise, tmo_hit;
  logic [2:0]    press_val;

  // Two-flop synchronizers for all asynchronous inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_s1 <= '0;
      keys_s2 <= '0;
      arm_s1  <= 1'b0;
      arm_s2  <= 1'b0;
      arm_d   <= 1'b0;
      clr_s1  <= 1'b0;
      clr_s2  <= 1'b0;
    end else begin
      keys_s1 <= keys;
      keys_s2 <= keys_s1;
      arm_s1  <= arm_req;
      arm_s2  <= arm_s1;
      arm_d   <= arm_s2;
      clr_s1  <= clear;
      clr_s2  <= clr_s1;
    end
  end

  // Per-key debounce; the debounced level flips after DEB_CYCLES consecutive differing cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        if (keys_s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= keys_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  assign press_any   = |press;
  assign press_multi = (press & (press - NK'(1))) != '0;
  assign arm_rise    = arm_s2 & ~arm_d;

  always_comb begin
    press_val = 3'd0;
    case (press)
      5'b00010: press_val = 3'd1;
      5'b00100: press_val = 3'd2;
      5'b01000: press_val = 3'd3;
      5'b10000: press_val = 3'd4;
      default:  press_val = 3'd0;
    endcase
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmr;
  logic          in_entry;

  assign in_entry = (state == S_ENTER) || (state == S_VERIFY);
  assign tmo_hit  = in_entry && (tmr == TW'(TIMEOUT_CYC - 1));

  // Inactivity counter, restarted by every press event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
    end else if (!in_entry || press_any) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TW'(1);
    end
  end
`else
  // Timer not built: TIMEOUT_CYC has no effect
  assign tmo_hit = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    nxt_state    = state;
    nxt_idx      = idx;
    nxt_shadow   = shadow;
    nxt_code     = code_out;
    nxt_valid    = code_valid;
    nxt_armed    = 1'b0;
    nxt_mismatch = 1'b0;
    nxt_led      = 8'h00;

    case (state)
      S_IDLE: begin
        if (arm_rise) begin
          nxt_state = S_ENTER;
          nxt_idx   = '0;
        end
      end
      S_ENTER: begin
        if (press_multi) begin
          nxt_mismatch = 1'b1;
        end else if (press_any) begin
          nxt_shadow[idx] = press_val;
          if (idx == IW'(CODE_LEN - 1)) begin
            nxt_state = S_VERIFY;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + IW'(1);
          end
        end
      end
      S_VERIFY: begin
        if (press_multi) begin
          nxt_mismatch = 1'b1;
        end else if (press_any) begin
          if (press_val == shadow[idx]) begin
            if (idx == IW'(CODE_LEN - 1)) begin
              nxt_state = S_ARMED;
              nxt_idx   = '0;
              nxt_valid = 1'b1;
              nxt_armed = 1'b1;
              for (int i = 0; i < CODE_LEN; i++) nxt_code[3*i +: 3] = shadow[i];
            end else begin
              nxt_idx = idx + IW'(1);
            end
          end else begin
            nxt_mismatch = 1'b1;
            nxt_state    = S_ENTER;
            nxt_idx      = '0;
            for (int i = 0; i < CODE_LEN; i++) nxt_shadow[i] = 3'd0;
          end
        end
      end
      default: ;
    endcase

    // Abort paths: timeout flags a mismatch, clear wins silently
    if (tmo_hit || (clr_s2 && (state != S_IDLE))) begin
      nxt_state    = S_IDLE;
      nxt_idx      = '0;
      nxt_code     = '0;
      nxt_valid    = 1'b0;
      nxt_armed    = 1'b0;
      nxt_mismatch = tmo_hit && !clr_s2;
      for (int i = 0; i < CODE_LEN; i++) nxt_shadow[i] = 3'd0;
    end

    case (nxt_state)
      S_ENTER: begin
        for (int i = 0; i < 8; i++) nxt_led[i] = 32'(nxt_idx) > 32'(i);
      end
      S_VERIFY: begin
        nxt_led[3:0] = 4'hF;
        for (int i = 0; i < 4; i++) nxt_led[4+i] = 32'(nxt_idx) > 32'(i);
      end
      S_ARMED: nxt_led = 8'hFF;
      default: nxt_led = 8'h00;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      for (int i = 0; i < CODE_LEN; i++) shadow[i] <= 3'd0;
      code_out   <= '0;
      code_valid <= 1'b0;
      armed      <= 1'b0;
      mismatch   <= 1'b0;
      prog_led   <= 8'h00;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      shadow     <= nxt_shadow;
      code_out   <= nxt_code;
      code_valid <= nxt_valid;
      armed      <= nxt_armed;
      mismatch   <= nxt_mismatch;
      prog_led   <= nxt_led;
    end
  end

endmodule

// File: tb/tb_code_arm_setter.sv
// Scoreboard bench for code_arm_setter: expected armed/mismatch events are queued with the stimulus.
module tb_code_arm_setter;

  localparam int unsigned CODE_LEN = 4;
  localparam int unsigned DEB      = 4;
  localparam int unsigned TMO      = 200;
  localparam int unsigned CW       = 3 * CODE_LEN;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    keys;
  logic          arm_req;
  logic          clear;
  logic [CW-1:0] code_out;
  logic          code_valid;
  logic          armed;
  logic          mismatch;
  logic [7:0]    prog_led;

  always #5 clk = ~clk;

  code_arm_setter #(
    .CODE_LEN   (CODE_LEN),
    .DEB_CYCLES (DEB),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .arm_req   (arm_req),
    .clear     (clear),
    .code_out  (code_out),
    .code_valid(code_valid),
    .armed     (armed),
    .mismatch  (mismatch),
    .prog_led  (prog_led)
  );

  typedef struct {
    logic [1:0]    kind;   // {armed, mismatch}
    logic [CW-1:0] code;
    logic          valid;
    logic [7:0]    led;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [CW-1:0] GOLD = 12'b010_000_100_001;
  localparam logic [4:0] K1 = 5'b00001, K2 = 5'b00010, K3 = 5'b00100,
                         K4 = 5'b01000, K5 = 5'b10000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [CW-1:0] code,
                            input logic valid, input logic [7:0] led);
    exp_t e;
    e.kind  = kind;
    e.code  = code;
    e.valid = valid;
    e.led   = led;
    sbq.push_back(e);
  endtask

  // Every armed/mismatch pulse cycle consumes one expectation; a 2-cycle pulse shows as unexpected
  always @(negedge clk) begin
    if (rst === 1'b1 && (armed || mismatch)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_evt", 32'({armed, mismatch}), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("evt_kind",  32'({armed, mismatch}), 32'(mon_e.kind));
        chk("evt_code",  32'(code_out),          32'(mon_e.code));
        chk("evt_valid", 32'(code_valid),        32'(mon_e.valid));
        chk("evt_led",   32'(prog_led),          32'(mon_e.led));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_keys(input logic [4:0] m);
    keys = m;
    tick(10);
    keys = 5'b0;
    tick(10);
  endtask

  task automatic pulse_arm();
    arm_req = 1'b1;
    tick(4);
    arm_req = 1'b0;
    tick(4);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(4);
    clear = 1'b0;
    tick(4);
  endtask

  initial begin
    rst     = 1'b0;
    keys    = 5'b0;
    arm_req = 1'b0;
    clear   = 1'b0;
    tick(3);
    chk("rst_code",     32'(code_out),   32'd0);
    chk("rst_valid",    32'(code_valid), 32'd0);
    chk("rst_armed",    32'(armed),      32'd0);
    chk("rst_mismatch", 32'(mismatch),   32'd0);
    chk("rst_led",      32'(prog_led),   32'd0);
    rst = 1'b1;
    tick(2);

    // Reset in the middle of entry
    pulse_arm();
    chk("enter_idx0", 32'(prog_led), 32'h00);
    press_keys(K2);
    chk("enter_idx1", 32'(prog_led), 32'h01);
    press_keys(K5);
    chk("enter_idx2", 32'(prog_led), 32'h03);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_led",   32'(prog_led),   32'd0);
    chk("midrst_valid", 32'(code_valid), 32'd0);
    chk("midrst_code",  32'(code_out),   32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Fresh entry restarts at idx 0
    pulse_arm();
    press_keys(K2);
    chk("restart_idx1", 32'(prog_led), 32'h01);
    press_keys(K5);
    chk("restart_idx2", 32'(prog_led), 32'h03);

    // Simultaneous k1+k3 is rejected, idx unchanged
    expect_evt(2'b01, '0, 1'b0, 8'h03);
    press_keys(K1 | K3);
    chk("multi_idx", 32'(prog_led), 32'h03);

    // Bouncing k1: one event only
    for (int b = 0; b < 3; b++) begin
      keys = K1;
      tick(3);
      keys = 5'b0;
      tick(1);
    end
    press_keys(K1);
    chk("bounce_idx", 32'(prog_led), 32'h07);

    // 3-cycle glitch on k3: no event
    keys = K3;
    tick(3);
    keys = 5'b0;
    tick(10);
    chk("glitch_idx", 32'(prog_led), 32'h07);

    press_keys(K3);
    chk("verify_idx0", 32'(prog_led), 32'h0F);

    // Wrong confirmation k2,k5,k4
    press_keys(K2);
    chk("verify_idx1", 32'(prog_led), 32'h1F);
    press_keys(K5);
    chk("verify_idx2", 32'(prog_led), 32'h3F);
    expect_evt(2'b01, '0, 1'b0, 8'h00);
    press_keys(K4);
    chk("vfail_led",   32'(prog_led),   32'h00);
    chk("vfail_valid", 32'(code_valid), 32'd0);

    // Correct entry and confirmation
    press_keys(K2);
    press_keys(K5);
    press_keys(K1);
    press_keys(K3);
    chk("reenter_led", 32'(prog_led), 32'h0F);
    press_keys(K2);
    press_keys(K5);
    press_keys(K1);
    chk("verify_idx3", 32'(prog_led), 32'h7F);
    expect_evt(2'b10, GOLD, 1'b1, 8'hFF);
    press_keys(K3);
    chk("armed_code",  32'(code_out),   32'(GOLD));
    chk("armed_valid", 32'(code_valid), 32'd1);
    chk("armed_led",   32'(prog_led),   32'hFF);

    // Keys and arm_req ignored while armed
    press_keys(K4);
    press_keys(K1 | K3);
    pulse_arm();
    chk("armed_hold_code", 32'(code_out), 32'(GOLD));
    chk("armed_hold_led",  32'(prog_led), 32'hFF);

    // Disarm, then clear in IDLE is harmless
    pulse_clear();
    chk("clr_code",  32'(code_out),   32'd0);
    chk("clr_valid", 32'(code_valid), 32'd0);
    chk("clr_led",   32'(prog_led),   32'h00);
    pulse_clear();
    chk("clr_idle_led", 32'(prog_led), 32'h00);

    // Inactivity after two presses
    pulse_arm();
    press_keys(K1);
    press_keys(K2);
    chk("tmo_pre_led", 32'(prog_led), 32'h03);
`ifdef ENTRY_TIMEOUT_EN
    expect_evt(2'b01, '0, 1'b0, 8'h00);
    tick(TMO + 20);
    chk("tmo_led", 32'(prog_led), 32'h00);
`else
    tick(TMO + 20);
    chk("notmo_led", 32'(prog_led), 32'h03);
`endif
    pulse_clear();
    chk("final_led", 32'(prog_led), 32'h00);

    tick(4);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
